// File: rtl/t02_ram_responder.sv
// Word-addressed RAM responder for the team-02 core's RAM bus.
// Each access is busy for a configurable number of cycles and then held until the requester drops its enables.
module t02_ram_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        Ren,
    input  logic        Wen,
    output logic [31:0] ramload,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] BASE_33  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_33 = BASE_33 + 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic           wr_q;
    logic           in_rng_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    data_q;
    logic [31:0]    ramload_q;
    logic           err_q;
    logic [31:0]    mem_q [DEPTH];

    // Window check and offset use 33 bits so an address below BASE_ADDR cannot wrap into range.
    logic [32:0]    addr_33;
    logic [32:0]    off_33;
    logic           in_rng_d;
    logic [AW-1:0]  idx_d;
    logic           unused_bits;
    logic           mem_we;

    assign addr_33     = {1'b0, ramaddr};
    assign off_33      = addr_33 - BASE_33;
    assign in_rng_d    = (addr_33 >= BASE_33) && (addr_33 < LIMIT_33);
    assign idx_d       = off_33[AW+1:2];
    assign unused_bits = ^{off_33[32:AW+2], off_33[1:0]};

    assign busy_o  = ((state_q == IDLE) && (Ren || Wen)) || (state_q == WAIT);
    assign ramload = ramload_q;
    assign err_o   = err_q;

    // The write fires only on the completion edge; an asserted reset holds state_q in IDLE and so discards it.
    assign mem_we = (state_q == WAIT) && (cnt_q == 4'd0) && wr_q && in_rng_q;

    // NOTE: the storage array has no reset branch, so it maps onto plain RAM and its contents survive nrst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= data_q;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            in_rng_q  <= 1'b0;
            idx_q     <= '0;
            data_q    <= 32'h0;
            ramload_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Ren || Wen) begin
                        wr_q     <= Wen;
                        in_rng_q <= in_rng_d;
                        idx_q    <= idx_d;
                        data_q   <= ramstore;
                        cnt_q    <= CNT_INIT;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        if (!wr_q) begin
                            ramload_q <= in_rng_q ? mem_q[idx_q] : 32'hDEAD_BEEF;
                        end
                        err_q   <= !in_rng_q;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (!Ren && !Wen) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t02_ram_responder.sv
// Directed bench for t02_ram_responder: a transaction-level timing model predicts busy/ramload/err every cycle,
// and literal expectations pin the key results.
module tb_t02_ram_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramload;
    logic        busy_o;
    logic        err_o;

    always #5 clk = ~clk;

    t02_ram_responder #(
        .DEPTH    (DEPTH),
        .LATENCY  (LATENCY),
        .BASE_ADDR(BASE)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .Ren     (Ren),
        .Wen     (Wen),
        .ramload (ramload),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic        exp_busy;
    logic [31:0] exp_ramload;
    logic        exp_err;
    int          busy_seen;
    int          err_seen;
    logic [31:0] mem_m [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_o", {31'b0, busy_o}, {31'b0, exp_busy});
            check("ramload", ramload, exp_ramload);
            check("err_o", {31'b0, err_o}, {31'b0, exp_err});
            if (busy_o) busy_seen++;
            if (err_o)  err_seen++;
        end
    end

    task automatic present(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        Ren       = rd;
        Wen       = wr;
        ramaddr   = addr;
        ramstore  = data;
        exp_busy  = 1'b1;
        busy_seen = 0;
        err_seen  = 0;
    endtask

    // From the first sampling edge: results land LATENCY edges later, then enables are held for 'hold' cycles.
    task automatic finish_access(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data, input int hold);
        @(posedge clk); #1;
        ramaddr  = $urandom;
        ramstore = $urandom;
        repeat (LATENCY) @(posedge clk);
        #1;
        exp_busy = 1'b0;
        exp_err  = !in_window(addr);
        if (wr) begin
            if (in_window(addr)) mem_m[widx(addr)] = data;
        end else if (rd) begin
            exp_ramload = in_window(addr) ? mem_m[widx(addr)] : 32'hDEAD_BEEF;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            exp_err = 1'b0;
        end
        Ren = 1'b0;
        Wen = 1'b0;
        @(posedge clk); #1;
        exp_err = 1'b0;
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input int hold);
        present(rd, wr, addr, data);
        finish_access(rd, wr, addr, data, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset held with a read request pending.
        nrst        = 1'b0;
        Ren         = 1'b1;
        Wen         = 1'b0;
        ramaddr     = 32'h0000_0404;
        ramstore    = 32'h0;
        exp_busy    = 1'b1;
        exp_ramload = 32'h0;
        exp_err     = 1'b0;
        busy_seen   = 0;
        err_seen    = 0;
        chk_en      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        finish_access(1'b1, 1'b0, 32'h0000_0404, 32'h0, 0);
        check("rst_read_value", ramload, 32'hDEAD_BEEF);
        check("rst_read_err_pulses", 32'(err_seen), 32'd1);

        do_access(1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 0);
        do_access(1'b0, 1'b1, 32'h0000_0008, 32'h0000_0001, 0);

        do_access(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0);
        check("write_busy_cycles", 32'(busy_seen), 32'd3);
        check("write_err_pulses", 32'(err_seen), 32'd0);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);
        check("read_busy_cycles", 32'(busy_seen), 32'd3);
        check("read_value_0x10", ramload, 32'hCAFE_F00D);
        check("read_err_pulses", 32'(err_seen), 32'd0);

        // Read with Ren held long after completion: only one access.
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 10);
        check("held_read_busy_cycles", 32'(busy_seen), 32'd3);
        check("held_read_value", ramload, 32'hCAFE_F00D);

        do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0);
        check("low_bits_ignored", ramload, 32'hCAFE_F00D);

        do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 0);
        check("oor_read_value", ramload, 32'hDEAD_BEEF);
        check("oor_read_err_pulses", 32'(err_seen), 32'd1);
        do_access(1'b0, 1'b1, 32'h0000_0400, 32'h0BAD_0BAD, 0);
        check("oor_write_err_pulses", 32'(err_seen), 32'd1);
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 0);
        check("word0_unchanged", ramload, 32'hA5A5_0001);

        do_access(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 0);
        check("both_en_no_load", ramload, 32'hA5A5_0001);
        do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0);
        check("both_en_was_write", ramload, 32'h1234_5678);

        do_access(1'b0, 1'b1, 32'h0000_03FC, 32'h600D_CAFE, 0);
        do_access(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 0);
        check("last_word", ramload, 32'h600D_CAFE);

        do_access(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 0);
        check("high_addr_value", ramload, 32'hDEAD_BEEF);
        check("high_addr_err_pulses", 32'(err_seen), 32'd1);

        // Reset pulsed during WAIT of a write: the write must be discarded.
        present(1'b0, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        nrst        = 1'b0;
        exp_ramload = 32'h0;
        exp_err     = 1'b0;
        exp_busy    = 1'b1;
        @(posedge clk); #1;
        Wen      = 1'b0;
        exp_busy = 1'b0;
        @(posedge clk); #1;
        check("reset_clears_ramload", ramload, 32'h0);
        nrst = 1'b1;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 0);
        check("reset_drops_write", ramload, 32'h0000_0001);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);
        check("mem_survives_reset", ramload, 32'hCAFE_F00D);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
